// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART_TX between NUM_REQ byte producers.
// Launches one frame at a time and follows tx_busy until the frame completes.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  output logic                          tx_data_valid,
  output logic [IDW-1:0]                grant_id,
  output logic                          frame_done,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    dv_q, dv_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    win_found_s;
  logic [IDW-1:0]          win_idx_s;
  logic [IDW-1:0]          cand_s;
  logic [DATA_WIDTH-1:0]   win_data_s;

  // Round-robin pick: scanning from farthest to nearest leaves the nearest set bit after rr_ptr.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s      = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      win_idx_s   = req_valid[cand_s] ? cand_s : win_idx_s;
      win_found_s = win_found_s | req_valid[cand_s];
    end
  end

  // Byte of the winning requester.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = (win_idx_s == IDW'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : win_data_s;
    end
  end

  // Next-state and registered-output logic; timeout set has priority over err_clr.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    p_data_d = p_data_q;
    grant_d  = grant_q;
    dv_d     = 1'b0;
    ready_d  = '0;
    done_d   = 1'b0;
    if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      IDLE: begin
        if (win_found_s && !tx_busy) begin
          p_data_d = win_data_s;
          ready_d  = NUM_REQ'(1'b1) << win_idx_s;
          dv_d     = 1'b1;
          grant_d  = win_idx_s;
          rr_ptr_d = win_idx_s;
          state_d  = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      cnt_q    <= '0;
      p_data_q <= '0;
      dv_q     <= 1'b0;
      ready_q  <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      p_data_q <= p_data_d;
      dv_q     <= dv_d;
      ready_q  <= ready_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tx_p_data     = p_data_q;
  assign tx_data_valid = dv_q;
  assign req_ready     = ready_q;
  assign grant_id      = grant_q;
  assign frame_done    = done_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple UART_TX busy model
// (busy for 10 cycles after each accepted Data_Valid).
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic tx_busy;
  logic [DW-1:0] tx_p_data;
  logic tx_data_valid;
  logic [1:0] grant_id;
  logic frame_done;
  logic timeout_err;
  logic err_clr = 1'b0;

  logic model_en = 1'b1;
  logic ext_busy = 1'b0;
  logic model_busy;
  logic [3:0] mcnt;
  logic [7:0] rx_log [0:31];
  int rx_n = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  assign tx_busy = model_busy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .grant_id(grant_id), .frame_done(frame_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // UART_TX model: latch byte on Data_Valid, then busy for 10 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      mcnt <= 4'd0;
    end else if (model_en && tx_data_valid && !model_busy) begin
      model_busy <= 1'b1;
      mcnt <= 4'd9;
      rx_log[rx_n[4:0]] <= tx_p_data;
      rx_n <= rx_n + 1;
    end else if (model_busy) begin
      if (mcnt == 4'd0) model_busy <= 1'b0;
      else mcnt <= mcnt - 4'd1;
    end
  end

  task automatic wait_grant(output logic ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, tx_p_data, tx_data_valid, grant_id, frame_done, timeout_err} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, tx_p_data, tx_data_valid, grant_id, frame_done, timeout_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic ok;
    int t0, rx0, nfd, tfd;
    @(negedge clk);
    rx0 = rx_n;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_grant(ok, t0);
    total++;
    if (!ok || {req_ready, tx_data_valid, tx_p_data, grant_id} !== {4'b0001, 1'b1, 8'hA5, 2'd0}) begin
      bad++;
      $display("FAIL single_launch: got rdy=%b dv=%b data=%h gid=%0d expected rdy=0001 dv=1 data=a5 gid=0",
               req_ready, tx_data_valid, tx_p_data, grant_id);
    end
    req_valid = 4'b0000;
    nfd = 0;
    tfd = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        total++;
        if ({req_ready, tx_data_valid} !== 5'b00000) begin
          bad++;
          $display("FAIL single_pulse_width: got rdy=%b dv=%b expected 0", req_ready, tx_data_valid);
        end
      end
      if (frame_done === 1'b1) begin
        nfd++;
        if (tfd < 0) tfd = n;
      end
    end
    total++;
    if (nfd != 1 || tfd != 12) begin
      bad++;
      $display("FAIL single_frame_done: got count=%0d at=%0d expected count=1 at=12", nfd, tfd);
    end
    total++;
    if (tx_p_data !== 8'hA5 || rx_log[rx0 % 32] !== 8'hA5) begin
      bad++;
      $display("FAIL single_data_hold: got pdata=%h rx=%h expected a5", tx_p_data, rx_log[rx0 % 32]);
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    int t, tprev, rx0;
    logic [3:0] exp_rdy;
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'h10; exp_b[1] = 8'h21; exp_b[2] = 8'h32; exp_b[3] = 8'h43;
    do_reset();
    rx0 = rx_n;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    tprev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(ok, t);
      exp_rdy = 4'b0001 << (g % 4);
      total++;
      if (!ok || grant_id !== 2'(g % 4) || req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rr_grant%0d: got gid=%0d rdy=%b expected gid=%0d rdy=%b",
                 g, grant_id, req_ready, g % 4, exp_rdy);
      end
      if (g > 0) begin
        total++;
        if (t - tprev != 13) begin
          bad++;
          $display("FAIL rr_spacing%0d: got %0d cycles expected 13", g, t - tprev);
        end
      end
      tprev = t;
      if (g == 4) req_valid = 4'b0000;
    end
    wait_done(ok);
    for (int g = 0; g < 5; g++) begin
      total++;
      if (!ok || rx_log[(rx0 + g) % 32] !== exp_b[g % 4]) begin
        bad++;
        $display("FAIL rr_uart_byte%0d: got %h expected %h", g, rx_log[(rx0 + g) % 32], exp_b[g % 4]);
      end
    end
  endtask

  task automatic test_wrap();
    logic ok;
    int t;
    do_reset();
    req_valid = 4'b0100;
    wait_grant(ok, t);
    req_valid = 4'b0000;
    total++;
    if (!ok || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL wrap_setup: got gid=%0d expected 2", grant_id);
    end
    wait_done(ok);
    req_valid = 4'b0011;
    wait_grant(ok, t);
    total++;
    if (!ok || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_first: got gid=%0d rdy=%b expected gid=0 rdy=0001", grant_id, req_ready);
    end
    wait_grant(ok, t);
    req_valid = 4'b0000;
    total++;
    if (!ok || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL wrap_second: got gid=%0d rdy=%b expected gid=1 rdy=0010", grant_id, req_ready);
    end
    wait_done(ok);
  endtask

  task automatic test_timeout();
    logic ok;
    int t, nfd, terr;
    logic e16, e17, e18;
    model_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    wait_grant(ok, t);
    req_valid = 4'b0000;
    nfd = 0;
    terr = -1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) nfd++;
      if (timeout_err === 1'b1 && terr < 0) terr = n;
    end
    total++;
    if (!ok || terr != 17 || nfd != 0) begin
      bad++;
      $display("FAIL timeout_set: got at=%0d frame_done=%0d expected at=17 frame_done=0", terr, nfd);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %b expected 0", timeout_err);
    end
    err_clr = 1'b1;
    req_valid = 4'b0001;
    wait_grant(ok, t);
    req_valid = 4'b0000;
    e16 = 1'bx; e17 = 1'bx; e18 = 1'bx;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 16) e16 = timeout_err;
      if (n == 17) e17 = timeout_err;
      if (n == 18) e18 = timeout_err;
    end
    err_clr = 1'b0;
    total++;
    if (!ok || {e16, e17, e18} !== 3'b010) begin
      bad++;
      $display("FAIL timeout_set_wins: got %b expected 010", {e16, e17, e18});
    end
    model_en = 1'b1;
  endtask

  task automatic test_ext_busy();
    logic ok;
    logic seen;
    @(negedge clk);
    ext_busy = 1'b1;
    req_valid = 4'b0100;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready != 4'b0000 || tx_data_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL ext_busy_hold: got grant=%b expected 0", seen);
    end
    ext_busy = 1'b0;
    @(negedge clk);
    req_valid = 4'b0000;
    total++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2 || tx_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL ext_busy_release: got rdy=%b gid=%0d dv=%b expected rdy=0100 gid=2 dv=1",
               req_ready, grant_id, tx_data_valid);
    end
    wait_done(ok);
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    int t;
    @(negedge clk);
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    wait_grant(ok, t);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    total++;
    if (!ok || tx_p_data !== 8'h5A || grant_id !== 2'd1 || tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_setup: got data=%h gid=%0d busy=%b expected 5a 1 1", tx_p_data, grant_id, tx_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, tx_p_data, tx_data_valid, grant_id, frame_done, timeout_err} !== 17'd0) begin
      bad++;
      $display("FAIL midframe_async_reset: got %h expected 0",
               {req_ready, tx_p_data, tx_data_valid, grant_id, frame_done, timeout_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    wait_grant(ok, t);
    req_valid = 4'b1000;
    total++;
    if (!ok || grant_id !== 2'd1 || req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL post_reset_ptr: got gid=%0d rdy=%b expected gid=1 rdy=0010", grant_id, req_ready);
    end
    wait_done(ok);
    wait_grant(ok, t);
    req_valid = 4'b0000;
    total++;
    if (!ok || grant_id !== 2'd3 || req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL post_reset_grant3: got gid=%0d rdy=%b expected gid=3 rdy=1000", grant_id, req_ready);
    end
    wait_done(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_ext_busy();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
